fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side control of the async FIFO, clocked entirely in the write domain (Clk).
//  Consumes the 2-flop-synchronised Gray read pointer (rd_syn_ptr) from rd2wr_synchronizer.
//  Produces the FIFO memory write strobe/address, full / almost_full flags and a fill level.
//  Exports the registered Gray write pointer to the wr->rd synchronizer.
// PARAMETERS
//  a_width    4   address bits; FIFO depth = 2**a_width; legal range a_width >= 2
//  AF_THRESH  12  almost_full asserts when registered level >= AF_THRESH (1..2**a_width)
// PORTS
//  Clk           in   1          write-domain clock
//  Resetn        in   1          reset, synchronous, active-low
//  wr_en         in   1          push request; data is accepted this cycle only if full==0
//  rd_syn_ptr    in   a_width+1  Gray read pointer, already synchronised into Clk domain
//  clr_overflow  in   1          clears the sticky overflow flag
//  mem_we        out  1          memory write enable = wr_en & ~full (combinational)
//  wr_addr       out  a_width    memory write address = wr_bin[a_width-1:0]
//  wr_ptr        out  a_width+1  registered Gray write pointer (to wr->rd synchronizer)
//  full          out  1          registered; FIFO holds 2**a_width entries (pessimistic)
//  almost_full   out  1          registered; level >= AF_THRESH
//  wr_level      out  a_width+1  registered fill count, 0..2**a_width (pessimistic)
//  overflow      out  1          sticky; set when wr_en==1 while full==1
// BEHAVIOUR
//  - Reset (Resetn==0 at posedge Clk): wr_bin=0, wr_ptr=0, full=0, almost_full=0,
//    wr_level=0, overflow=0. Resetn has priority over every other input.
//  - push = wr_en & ~full. wr_bin_next = wr_bin + push (mod 2**(a_width+1)).
//    wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next. wr_bin, wr_ptr <= next values.
//  - full <= (wr_gray_next == {~rd_syn_ptr[a_width:a_width-1], rd_syn_ptr[a_width-2:0]}).
//    Flag reflects the pointer after this cycle's push; a write that fills the last slot
//    raises full on the same edge that commits the write, with 0 extra cycles.
//  - rd_bin = Gray-to-binary of rd_syn_ptr (XOR-prefix from MSB).
//    wr_level <= wr_bin_next - rd_bin (a_width+1 bits, modulo arithmetic, no saturation).
//    almost_full <= (wr_level_next >= AF_THRESH).
//  - Read-pointer motion is seen 2 Clk cycles late (synchronizer) plus 1 cycle here, so
//    full / level may stay pessimistic for up to 3 cycles after a read. This is correct
//    behaviour; the FIFO never over-writes.
//  - Wrap-around: wr_bin rolls 2**(a_width+1)-1 -> 0. Gray stays single-bit-change.
//    Level and full remain correct across the wrap.
//  - Write while full: no pointer change, mem_we=0, overflow<=1.
//    clr_overflow and a new overflow event in the same cycle: set wins.
//  - Write while read pointer moves in the same cycle: both are honoured. Level uses the
//    new wr_bin and the current rd_syn_ptr.
//  - Reset mid-operation zeroes the pointer. The read side must be reset in the same
//    window; this block does not check that.
// STRUCTURE
//  - Shared package fifo_pkg: default a_width, depth localparam (1<<a_width),
//    and function gray2bin / bin2gray for reuse by fifo_rd_ctrl.
//  - One natural sub-module: gray2bin_conv #(W) (combinational, instantiated for rd_syn_ptr).
//    Everything else is flat in this module.
// TESTING (a_width=4, AF_THRESH=12, rd_syn_ptr driven directly)
//  1. Reset, then 16 consecutive wr_en with rd_syn_ptr=0 -> wr_addr 0..15, mem_we=1 x16;
//     full=1 after 16th edge; wr_ptr=5'b11000 (Gray of 16); wr_level=16.
//  2. Continue from 1 with wr_en=1 for 2 more cycles -> mem_we=0, wr_ptr stays 5'b11000,
//     overflow=1; pulse clr_overflow with wr_en=0 -> overflow=0.
//  3. From full, set rd_syn_ptr=Gray(1)=5'b00001 -> one cycle later full=0, wr_level=15;
//     one push -> full=1 again, wr_addr was 0.
//  4. almost_full: push 11 -> almost_full=0; 12th push -> almost_full=1 on that edge.
//  5. Wrap: keep rd_syn_ptr = Gray(wr_bin-4) while pushing 40 times -> wr_bin wraps past
//     31; wr_level constant 4, full never set, each wr_ptr step changes exactly 1 bit.
//  6. Drive Resetn=0 for one edge mid-burst with wr_en=1 -> all outputs zero next cycle;
//     no mem_we during the reset cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO read and write controllers.
//   A_WIDTH  : default address width (FIFO depth = 2**A_WIDTH)
//   DEPTH    : default FIFO depth
//   bin2gray : binary -> reflected Gray code (32-bit, callers truncate)
//   gray2bin : reflected Gray code -> binary (32-bit, callers truncate)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned A_WIDTH = 4;
    localparam int unsigned DEPTH   = 1 << A_WIDTH;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = '0;
        for (int i = 0; i < 32; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Combinational Gray-to-binary converter of width W.
// Ports:
//   gray_i  in   W   Gray-coded value
//   bin_o   out  W   binary equivalent
// -----------------------------------------------------------------------------
module gray2bin_conv #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        // XOR-prefix from the MSB down.
        for (int i = 0; i < W; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side control of the async FIFO, entirely in the Clk domain.
// Ports:
//   Clk           in   1          write-domain clock
//   Resetn        in   1          synchronous active-low reset
//   wr_en         in   1          push request (accepted only while full==0)
//   rd_syn_ptr    in   a_width+1  synchronised Gray read pointer
//   clr_overflow  in   1          clears the sticky overflow flag
//   mem_we        out  1          memory write strobe (combinational)
//   wr_addr       out  a_width    memory write address
//   wr_ptr        out  a_width+1  registered Gray write pointer
//   full          out  1          registered full flag (pessimistic)
//   almost_full   out  1          registered, level >= AF_THRESH
//   wr_level      out  a_width+1  registered fill level (pessimistic)
//   overflow      out  1          sticky write-while-full flag
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned a_width   = A_WIDTH,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic               Clk,
    input  logic               Resetn,
    input  logic               wr_en,
    input  logic [a_width:0]   rd_syn_ptr,
    input  logic               clr_overflow,
    output logic               mem_we,
    output logic [a_width-1:0] wr_addr,
    output logic [a_width:0]   wr_ptr,
    output logic               full,
    output logic               almost_full,
    output logic [a_width:0]   wr_level,
    output logic               overflow
);

    localparam int unsigned PW = a_width + 1;

    logic [PW-1:0] wr_bin_q, wr_bin_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] full_gray;
    logic          push;

    gray2bin_conv #(
        .W (PW)
    ) u_rd_g2b (
        .gray_i (rd_syn_ptr),
        .bin_o  (rd_bin)
    );

    assign push = wr_en & ~full_q;

    // Full when the write pointer is one lap ahead: Gray form inverts the top two bits.
    assign full_gray = {~rd_syn_ptr[a_width -: 2], rd_syn_ptr[a_width-2:0]};

    always_comb begin
        wr_bin_d = wr_bin_q + PW'(push);
        wr_ptr_d = PW'(bin2gray(32'(wr_bin_d)));
        full_d   = (wr_ptr_d == full_gray);
        level_d  = wr_bin_d - rd_bin;
        af_d     = (32'(level_d) >= AF_THRESH);
        // A new overflow event wins over a simultaneous clear.
        ovf_d    = (wr_en & full_q) | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            wr_bin_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_bin_q <= wr_bin_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    // The strobe is suppressed while reset is held so no write lands in a reset cycle.
    assign mem_we      = push & Resetn;
    assign wr_addr     = wr_bin_q[a_width-1:0];
    assign wr_ptr      = wr_ptr_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

    logic       Clk = 1'b0;
    logic       Resetn;
    logic       wr_en;
    logic [4:0] rd_syn_ptr;
    logic       clr_overflow;
    logic       mem_we;
    logic [3:0] wr_addr;
    logic [4:0] wr_ptr;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       overflow;

    int vectors = 0;
    int errors  = 0;

    // Reference model: total words written / read as plain integers.
    int  m_w   = 0;
    int  m_r   = 0;
    bit  m_full = 0;
    bit  m_ov   = 0;
    int  m_lvl  = 0;

    fifo_wr_ctrl #(
        .a_width   (4),
        .AF_THRESH (12)
    ) dut (
        .Clk          (Clk),
        .Resetn       (Resetn),
        .wr_en        (wr_en),
        .rd_syn_ptr   (rd_syn_ptr),
        .clr_overflow (clr_overflow),
        .mem_we       (mem_we),
        .wr_addr      (wr_addr),
        .wr_ptr       (wr_ptr),
        .full         (full),
        .almost_full  (almost_full),
        .wr_level     (wr_level),
        .overflow     (overflow)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] gray5(input int n);
        int v;
        v = n % 32;
        return 5'(v ^ (v >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".wr_ptr"},   32'(wr_ptr),      32'(gray5(m_w)));
        chk({tag, ".wr_addr"},  32'(wr_addr),     32'(m_w % 16));
        chk({tag, ".full"},     32'(full),        32'(m_full));
        chk({tag, ".af"},       32'(almost_full), 32'(m_lvl >= 12));
        chk({tag, ".level"},    32'(wr_level),    32'(m_lvl));
        chk({tag, ".overflow"}, 32'(overflow),    32'(m_ov));
    endtask

    task automatic do_reset();
        Resetn       = 1'b0;
        wr_en        = 1'b1;
        clr_overflow = 1'b0;
        rd_syn_ptr   = '0;
        #1;
        chk("reset.mem_we", 32'(mem_we), 32'd0);
        @(posedge Clk);
        #1;
        m_w = 0; m_r = 0; m_full = 0; m_ov = 0; m_lvl = 0;
        Resetn = 1'b1;
        wr_en  = 1'b0;
        chk_regs("reset");
    endtask

    // One clock with the given inputs; rd is the read count the synchronised pointer shows.
    task automatic cycle(input bit we, input bit clr, input int rd, input string tag);
        bit push;
        wr_en        = we;
        clr_overflow = clr;
        rd_syn_ptr   = gray5(rd);
        m_r          = rd;
        #1;
        push = we && !m_full;
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(push));
        @(posedge Clk);
        #1;
        m_ov   = (we && m_full) || (m_ov && !clr);
        m_w    = m_w + int'(push);
        m_lvl  = (m_w - m_r) % 32;
        m_full = (m_lvl == 16);
        chk_regs(tag);
    endtask

    initial begin
        logic [4:0] prev_ptr;
        int         step;

        Resetn = 1'b0; wr_en = 1'b0; clr_overflow = 1'b0; rd_syn_ptr = '0;
        @(posedge Clk);
        #1;
        do_reset();

        // Fill from empty.
        for (int i = 0; i < 16; i++) begin
            chk("fill.addr_pre", 32'(wr_addr), 32'(i));
            cycle(1'b1, 1'b0, 0, "fill");
        end
        chk("fill.ptr_const", 32'(wr_ptr), 32'h18);
        chk("fill.full_const", 32'(full), 32'd1);

        // Writes while full.
        cycle(1'b1, 1'b0, 0, "ovf");
        cycle(1'b1, 1'b0, 0, "ovf");
        chk("ovf.ptr_const", 32'(wr_ptr), 32'h18);
        cycle(1'b1, 1'b1, 0, "ovf_set_wins");
        cycle(1'b0, 1'b1, 0, "ovf_clr");

        // Read one word: full drops, then one more push refills.
        cycle(1'b0, 1'b0, 1, "rd1");
        chk("rd1.addr_pre", 32'(wr_addr), 32'd0);
        cycle(1'b1, 1'b0, 1, "refill");

        // almost_full threshold.
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0, "af");

        // Wrap-around with constant level of 4.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0, "wrap_pre");
        for (int i = 0; i < 40; i++) begin
            prev_ptr = wr_ptr;
            cycle(1'b1, 1'b0, m_w + 1 - 4, "wrap");
            chk("wrap.onebit", 32'($countones(prev_ptr ^ wr_ptr)), 32'd1);
        end

        // Reset mid-burst.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, m_r, "burst");
        do_reset();

        // Randomised traffic with a monotonic read count that never passes the writes.
        for (int i = 0; i < 300; i++) begin
            step = (m_w - m_r > 0) ? int'($urandom_range(0, 2)) : 0;
            if (step > m_w - m_r) step = m_w - m_r;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  m_r + step, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
